// File: rtl/cpu_fetch_unit.sv
// Instruction fetch/issue stage: holds the PC, fetches over a ready handshake,
// presents the instruction to decode and selects the next PC on retire.
module cpu_fetch_unit #(
  parameter int                  PC_WIDTH    = 16,
  parameter int                  INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = 16'h0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_rdy,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [2:0]             cpu_opcode,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   cpu_jump,
  input  logic                   cpu_branch,
  input  logic                   alu_zero,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [PC_WIDTH-1:0]    pc_plus2,
  output logic [15:0]            retire_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, ISSUE} state_t;
  state_t state;

  logic [PC_WIDTH-1:0] next_pc, jmp_tgt, br_off;

  assign pc_plus2    = pc + PC_WIDTH'(2);
  assign imem_addr   = pc;
  assign imem_req    = (state == REQ);
  assign instr_valid = (state == ISSUE);
  assign cpu_opcode  = instr[INSTR_WIDTH-1 -: 3];

  // Jump keeps the region bits of pc+2; branch offset is a signed halfword count.
  assign jmp_tgt = {pc_plus2[PC_WIDTH-1:14], instr[12:0], 1'b0};
  assign br_off  = {{(PC_WIDTH-8){instr[6]}}, instr[6:0], 1'b0};

  always_comb begin
    next_pc = pc_plus2;
    if (cpu_jump)                   next_pc = jmp_tgt;
    else if (cpu_branch && alu_zero) next_pc = pc_plus2 + br_off;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      instr      <= '0;
      retire_cnt <= '0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: if (imem_rdy) begin
          instr <= imem_rdata;
          state <= ISSUE;
        end
        ISSUE: if (instr_ready) begin
          pc         <= next_pc;
          retire_cnt <= retire_cnt + 16'd1;
          state      <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cpu_fetch_unit.md
# cpu_fetch_unit

Instruction fetch and issue stage for the 16-bit MIPS processor, on the producer side of the decode interface. It holds the program counter, fetches 16-bit instructions from instruction memory over a ready-based handshake, and presents each instruction and its `cpu_opcode` to the control unit. It then consumes the resolved `cpu_jump` / `cpu_branch` controls and the ALU zero flag to select the next PC.

## Interface
- `PC_WIDTH`, 16, program counter and instruction-memory address width (byte address, halfword aligned)
- `INSTR_WIDTH`, 16, instruction width; opcode is `instr[15:13]`
- `RESET_PC`, 16'h0000, PC value loaded on reset
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  fetch request to instruction memory
- `imem_addr`  out  PC_WIDTH  fetch address, equal to `pc`
- `imem_rdy`  in  1  memory has valid `imem_rdata` this cycle
- `imem_rdata`  in  INSTR_WIDTH  fetched instruction
- `instr`  out  INSTR_WIDTH  registered instruction presented to decode
- `cpu_opcode`  out  3  `instr[15:13]`, feeds the control unit
- `instr_valid`  out  1  `instr` / `cpu_opcode` valid
- `instr_ready`  in  1  downstream accepts the instruction this cycle (retire)
- `cpu_jump`  in  1  from control unit; sampled only on the handshake cycle
- `cpu_branch`  in  1  from control unit; sampled only on the handshake cycle
- `alu_zero`  in  1  ALU equality result; sampled only on the handshake cycle
- `pc`  out  PC_WIDTH  address of the current instruction
- `pc_plus2`  out  PC_WIDTH  `pc + 2` mod 2^16, for link and branch use
- `retire_cnt`  out  16  count of retired instructions, wraps

## Operation
- FSM states: IDLE, REQ, ISSUE.
  - IDLE: entered on reset; moves to REQ unconditionally on the next clock.
  - REQ: `imem_req=1`, `imem_addr=pc` held stable. When `imem_rdy=1`, capture `imem_rdata` into `instr` and go to ISSUE; otherwise stay in REQ.
  - ISSUE: `instr_valid=1`, `instr` held stable. When `instr_ready=1` (handshake), load `pc <= next_pc`, increment `retire_cnt`, and go to REQ; otherwise stay in ISSUE.
- `imem_req = (state==REQ)`; `instr_valid = (state==ISSUE)`; both are decoded from registered state.
- next_pc is evaluated on the handshake cycle only, in this priority order:
  1. `cpu_jump=1`: `{pc_plus2[15:14], instr[12:0], 1'b0}`.
  2. `cpu_branch=1 && alu_zero=1`: `pc_plus2 + (sext16(instr[6:0]) << 1)`, mod 2^16.
  3. Otherwise: `pc_plus2`.
- Only `cpu_jump` redirects as a jump; opcodes that do not assert it fall through to branch or sequential selection.
- All PC arithmetic is 16-bit and drops the carry: `pc=16'hFFFE` increments to `16'h0000`.
- `imem_rdy` outside REQ is ignored. `instr_ready` outside ISSUE is ignored.
- Reset values:
  - state=IDLE, `pc=RESET_PC`, `instr=16'h0000`, `retire_cnt=0`.
  - Therefore `cpu_opcode=3'b000`, `imem_req=0`, `instr_valid=0`, `imem_addr=RESET_PC`, `pc_plus2=RESET_PC+2`.
- Reset mid-operation (any state, including an outstanding REQ): all state returns immediately to reset values. Any in-flight memory response is discarded. Fetch restarts at `RESET_PC`.

## Timing
- First `imem_req` is asserted in the 2nd rising edge after `rst_n` deasserts (IDLE lasts one cycle).
- With a zero-wait memory (`imem_rdy=1` in the REQ cycle), the instruction is visible on `instr` the next cycle.
- Throughput: one instruction per 2 cycles with zero-wait memory and `instr_ready` held high. Each memory wait cycle and each `instr_ready=0` cycle adds one cycle.
- `pc`, `imem_addr`, and `instr` never change except on the REQ->ISSUE transition (`instr`) or the ISSUE->REQ transition (`pc`).
- `cpu_jump`, `cpu_branch`, and `alu_zero` may be combinational functions of `cpu_opcode` / `instr`; only their value in the handshake cycle matters.

## Test plan
- Reset then sequential run: `RESET_PC=0`, memory returns an add (opcode 000) at 0,2,4, `instr_ready=1`, zero wait -> `imem_addr` sequence 0,2,4; `instr_valid` high every other cycle; `retire_cnt=3` after the third handshake.
- Wait states and stall: `imem_rdy` low for 3 cycles, then `instr_ready` low for 2 cycles -> `imem_req` and `imem_addr` stable for 4 cycles; `instr` stable while `instr_valid=1`; exactly one retire.
- Jump: `pc=16'h4010`, `instr=16'h4123`, `cpu_jump=1` -> next `imem_addr=16'h4246`.
- Branch: `pc=16'h0100`, `instr[6:0]=7'h7E` (-2), `cpu_branch=1`.
  - With `alu_zero=1` -> next PC `16'h00FE`.
  - Same case with `alu_zero=0` -> next PC `16'h0102`.
- Priority and wrap: `cpu_jump=1` and `cpu_branch=1` with `alu_zero=1` -> jump target taken. Sequential retire at `pc=16'hFFFE` -> next `imem_addr=16'h0000`. `retire_cnt` at `16'hFFFF` plus one retire -> `16'h0000`.
- Reset mid-fetch: assert `rst_n=0` while in REQ with `imem_rdy=0` -> `imem_req=0` and `instr_valid=0` immediately (asynchronously), `pc=RESET_PC`. A late `imem_rdy` pulse during reset is not captured.
